// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: sequencer states and the
// memory access size codes (also used by the instruction decoder).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_READ = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  function automatic logic is_write(input logic [1:0] size);
    return (size != SZ_READ);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Winner select for the two requesters. With ARB_ROUND_ROBIN_EN defined a
// last-grant register alternates between simultaneous requesters; otherwise port 0 has fixed priority.
module mem_arb_grant (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic grant_stb,
  output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
  logic last_d;

  // Contended requests go to the port not granted last.
  always_comb begin
    if (req0 && req1) begin
      winner = ~last_q;
    end else begin
      winner = ~req0 & req1;
    end
    if (grant_stb) begin
      last_d = winner;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant register; reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = clk ^ rst ^ grant_stb;

  // Fixed priority: port 1 only wins when port 0 is idle.
  always_comb begin
    winner = ~req0 & req1;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter/sequencer: serialises port 0 and port 1 accesses,
// applies read latency and write-done/timeout, one ack per transaction. Option: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int WR_TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [1:0]            size0,
  input  logic [1:0]            size1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_SIZE-1:0]  wdata0,
  input  logic [WORD_SIZE-1:0]  wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [WORD_SIZE-1:0]  rdata0,
  output logic [WORD_SIZE-1:0]  rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [1:0]            mem_write,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  mem_done,
  input  logic                  mem_error
);

  localparam logic [31:0] RD_LOAD = 32'(READ_LATENCY - 1);
  localparam logic [31:0] WR_LOAD = 32'(WR_TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic                  grant_q, grant_d;
  logic [1:0]            size_q, size_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [1:0]            mem_write_q, mem_write_d;
  logic [WORD_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [WORD_SIZE-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;

  logic       winner_s;
  logic       grant_stb_s;
  logic [1:0] sel_size_s;
  logic       fin_s;
  logic       fin_err_s;

  mem_arb_grant u_grant (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .grant_stb (grant_stb_s),
    .winner    (winner_s)
  );

  // Sequencer next-state: arbitrate, count read latency, wait for write done, pulse ack.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    mem_write_d   = mem_write_q;
    mem_wdata_d   = mem_wdata_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    err0_d        = err0_q;
    err1_d        = err1_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    grant_stb_s   = 1'b0;
    sel_size_s    = winner_s ? size1 : size0;
    fin_s         = 1'b0;
    fin_err_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_stb_s   = 1'b1;
          grant_d       = winner_s;
          size_d        = sel_size_s;
          mem_address_d = winner_s ? addr1 : addr0;
          mem_wdata_d   = winner_s ? wdata1 : wdata0;
          if (is_write(sel_size_s)) begin
            state_d     = ST_WRITE;
            mem_write_d = sel_size_s;
            cnt_d       = WR_LOAD;
          end else begin
            state_d     = ST_READ;
            mem_write_d = SZ_READ;
            cnt_d       = RD_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cnt_q == 32'd0) begin
          fin_s     = 1'b1;
          fin_err_s = mem_error;
          if (grant_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_WRITE: begin
        // A done that lands on the timeout clock still counts as done.
        if (mem_done || (cnt_q == 32'd0)) begin
          fin_s       = 1'b1;
          fin_err_s   = mem_done ? mem_error : 1'b1;
          mem_write_d = SZ_READ;
        end else begin
          cnt_d       = cnt_q - 32'd1;
          mem_write_d = size_q;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_write_d = SZ_READ;
      end
    endcase
    if (fin_s) begin
      state_d = ST_ACK;
      if (grant_q) begin
        ack1_d = 1'b1;
        err1_d = fin_err_s;
      end else begin
        ack0_d = 1'b1;
        err0_d = fin_err_s;
      end
    end else begin
      ack0_d = 1'b0;
      ack1_d = 1'b0;
    end
  end

  // State and output registers; reset drops mem_write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      size_q        <= SZ_READ;
      cnt_q         <= 32'd0;
      mem_address_q <= '0;
      mem_write_q   <= SZ_READ;
      mem_wdata_q   <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      size_q        <= size_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign mem_address = mem_address_q;
  assign mem_write   = mem_write_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory responder,
// word-level reference memory and transaction-level latency/arbitration model.
module tb_mem_port_arbiter;

  localparam int RL  = 2;
  localparam int WTO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [1:0]  mem_write;
  logic        mem_done = 1'b0;
  logic        mem_error;

  int total = 0;
  int bad   = 0;

  // Memory environment state.
  logic [7:0]  mem_b [0:255];
  int          done_after = 0;
  int          wr_cycles  = 0;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = 8'd0;
  logic [31:0] pre_data = 32'd0;

  // Reference model state.
  logic [31:0] model_mem [0:63];
  logic        model_err [0:1];
  int          model_last;

  mem_port_arbiter #(.WORD_SIZE(32), .ADDR_WIDTH(32), .READ_LATENCY(RL), .WR_TIMEOUT(WTO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .size0(size0), .size1(size1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == 2'b10) && a[0]) || ((sz == 2'b11) && (a != 2'b00));
  endfunction

  function automatic int pick(input bit p0, input bit p1, input int last);
    if (p0 && p1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return p0 ? 0 : 1;
  endfunction

  logic [7:0] ra;
  assign ra        = {mem_address[7:2], 2'b00};
  assign mem_rdata = {mem_b[ra + 8'd3], mem_b[ra + 8'd2], mem_b[ra + 8'd1], mem_b[ra]};
  assign mem_error = misaligned(mem_write, mem_address[1:0]);

  // Memory responder: preload port, plus write completion after done_after clocks (0 = never).
  always @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < 4; i++) mem_b[pre_addr + 8'(i)] <= pre_data[8*i +: 8];
    end
    if (mem_write != 2'b00 && !mem_done) begin
      wr_cycles <= wr_cycles + 1;
      if (done_after != 0 && wr_cycles + 1 == done_after) begin
        mem_done <= 1'b1;
        if (!mem_error) begin
          case (mem_write)
            2'b01: mem_b[mem_address[7:0]] <= mem_wdata[7:0];
            2'b10: begin
              mem_b[mem_address[7:0]]        <= mem_wdata[7:0];
              mem_b[mem_address[7:0] + 8'd1] <= mem_wdata[15:8];
            end
            default: for (int i = 0; i < 4; i++) mem_b[ra + 8'(i)] <= mem_wdata[8*i +: 8];
          endcase
        end
      end
    end else begin
      wr_cycles <= 0;
      mem_done  <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    model_mem[a[7:2]] = d;
  endtask

  task automatic run_txn(input string tag, input int p, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input int dly);
    int edges, exp_edges;
    bit got, other_seen, mw_ok, is_wr;
    logic exp_err;
    logic [1:0] exp_mw;
    is_wr = (sz != 2'b00);
    if (!is_wr) begin
      exp_edges = RL + 1; exp_err = 1'b0;
    end else if (dly > 0 && dly + 1 <= WTO) begin
      exp_edges = dly + 2; exp_err = misaligned(sz, a[1:0]);
    end else begin
      exp_edges = WTO + 1; exp_err = 1'b1;
    end
    done_after = dly;
    if (p == 0) begin req0 = 1'b1; size0 = sz; addr0 = a; wdata0 = wd; end
    else        begin req1 = 1'b1; size1 = sz; addr1 = a; wdata1 = wd; end
    edges = 0; got = 0; other_seen = 0; mw_ok = 1;
    while (!got && edges < 200) begin
      @(posedge clk); edges++;
      @(negedge clk);
      got = ((p == 0) ? ack0 : ack1) === 1'b1;
      if (((p == 0) ? ack1 : ack0) !== 1'b0) other_seen = 1;
      exp_mw = (is_wr && !got) ? sz : 2'b00;
      if (mem_write !== exp_mw) mw_ok = 0;
    end
    chk({tag, " ack_seen"}, 32'(got), 32'd1);
    chk({tag, " ack_latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, " other_ack_quiet"}, 32'(other_seen), 32'd0);
    chk({tag, " mem_write_profile"}, 32'(mw_ok), 32'd1);
    chk({tag, " mem_address"}, mem_address, a);
    chk({tag, " err"}, 32'((p == 0) ? err0 : err1), 32'(exp_err));
    chk({tag, " other_err_hold"}, 32'((p == 0) ? err1 : err0), 32'(model_err[1-p]));
    if (!is_wr) chk({tag, " rdata"}, (p == 0) ? rdata0 : rdata1, model_mem[a[7:2]]);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
    chk({tag, " ack_one_clock"}, 32'((p == 0) ? ack0 : ack1), 32'd0);
    if (is_wr && !exp_err && sz == 2'b11) model_mem[a[7:2]] = wd;
    model_err[p] = exp_err;
    model_last   = p;
  endtask

  initial begin
    int acks, edges, guard, who, exp_next, p, dly;
    bit pend0, pend1, rr0, rr1, ack_flag;
    logic [31:0] a, d;

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; size0 = 2'b00; size1 = 2'b00;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    model_last = 1; model_err[0] = 1'b0; model_err[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ack0", 32'(ack0), 32'd0);
    chk("reset ack1", 32'(ack1), 32'd0);
    chk("reset err0", 32'(err0), 32'd0);
    chk("reset err1", 32'(err1), 32'd0);
    chk("reset rdata0", rdata0, 32'd0);
    chk("reset rdata1", rdata1, 32'd0);
    chk("reset mem_address", mem_address, 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    preload(8'h10, 32'hDEADBEEF);
    run_txn("p0_read_10", 0, 2'b00, 32'h10, 32'd0, 0);
    run_txn("p1_word_write_20", 1, 2'b11, 32'h20, 32'h12345678, 4);
    run_txn("p0_read_20", 0, 2'b00, 32'h20, 32'd0, 0);

    // Both ports hold read requests; each acked port re-requests until four are served.
    pend0 = 1; pend1 = 1; rr0 = 0; rr1 = 0;
    req0 = 1'b1; size0 = 2'b00; addr0 = 32'h10;
    req1 = 1'b1; size1 = 2'b00; addr1 = 32'h20;
    exp_next = pick(1'b1, 1'b1, model_last);
    acks = 0; edges = 0; guard = 0;
    while (acks < 5 && guard < 300) begin
      @(posedge clk); edges++; guard++;
      @(negedge clk);
      if (rr0) begin req0 = 1'b1; rr0 = 0; end
      if (rr1) begin req1 = 1'b1; rr1 = 0; end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        who = (ack1 === 1'b1) ? 1 : 0;
        chk($sformatf("contend order #%0d", acks), 32'(who), 32'(exp_next));
        chk($sformatf("contend gap #%0d", acks), 32'(edges), 32'((acks == 0) ? RL + 1 : RL + 2));
        chk($sformatf("contend rdata #%0d", acks), (who == 1) ? rdata1 : rdata0,
            model_mem[(who == 1) ? 8 : 4]);
        model_last = who; acks++; edges = 0;
        if (who == 1) begin req1 = 1'b0; pend1 = (acks < 4); rr1 = (acks < 4); end
        else          begin req0 = 1'b0; pend0 = (acks < 4); rr0 = (acks < 4); end
        exp_next = pick(pend0, pend1, model_last);
      end
    end
    chk("contend served", 32'(acks), 32'd5);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    run_txn("p0_write_timeout", 0, 2'b11, 32'h30, 32'hAAAA5555, 0);
    run_txn("p1_done_at_timeout", 1, 2'b11, 32'h34, 32'hCAFEF00D, WTO - 1);
    run_txn("p0_read_34", 0, 2'b00, 32'h34, 32'd0, 0);
    run_txn("p1_misaligned_half", 1, 2'b10, 32'h21, 32'h0000BEEF, 3);
    run_txn("p1_read_after_err", 1, 2'b00, 32'h20, 32'd0, 0);

    // Reset while a write is outstanding.
    done_after = 0;
    req0 = 1'b1; size0 = 2'b11; addr0 = 32'h38; wdata0 = 32'h0BADF00D;
    repeat (3) @(negedge clk);
    chk("rst_mid mem_write before", 32'(mem_write), 32'd3);
    rst = 1'b0;
    #1;
    chk("rst_mid mem_write async", 32'(mem_write), 32'd0);
    chk("rst_mid ack0", 32'(ack0), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    chk("rst_mid err0", 32'(err0), 32'd0);
    chk("rst_mid err1", 32'(err1), 32'd0);
    chk("rst_mid rdata0", rdata0, 32'd0);
    rst = 1'b1;
    model_last = 1; model_err[0] = 1'b0; model_err[1] = 1'b0;
    ack_flag = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack0 !== 1'b0 || ack1 !== 1'b0) ack_flag = 1;
    end
    chk("rst_mid no_ack", 32'(ack_flag), 32'd0);
    run_txn("post_reset_read", 0, 2'b00, 32'h10, 32'd0, 0);

    for (int i = 0; i < 10; i++) begin
      p   = int'($urandom_range(0, 1));
      a   = 32'h40 + 32'(4 * $urandom_range(0, 15));
      d   = $urandom;
      dly = int'($urandom_range(1, 6));
      run_txn($sformatf("rnd_wr%0d", i), p, 2'b11, a, d, dly);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
      run_txn($sformatf("rnd_rd%0d", i), 1 - p, 2'b00, a, 32'd0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
